// File: rtl/oclib_pkg.sv
// +----------------------------------------------------------------------------+
// | oclib_pkg                                                                  |
// | Shared CSR bus types, block IDs and CSR splitter state/constants.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package oclib_pkg;

  localparam logic [3:0]  BcBlockIdAny      = 4'hF;
  localparam logic [31:0] CsrSplitErrorData = 32'h0;

  typedef struct packed {
    logic [3:0]  toblock;
    logic [3:0]  space;
    logic [31:0] address;
    logic [31:0] wdata;
    logic        read;
    logic        write;
  } csr_32_s;

  typedef struct packed {
    logic [31:0] rdata;
    logic        ready;
    logic        error;
  } csr_32_fb_s;

  typedef enum logic [2:0] {
    CsrSplitStateIdle    = 3'd0,
    CsrSplitStateDecode  = 3'd1,
    CsrSplitStateIssue   = 3'd2,
    CsrSplitStateRespond = 3'd3,
    CsrSplitStateRelease = 3'd4
  } csr_split_state_e;

  function automatic logic [15:0] satInc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/oclib_csr_space_decode.sv
// +----------------------------------------------------------------------------+
// | oclib_csr_space_decode                                                     |
// | Combinational space-to-port priority match; lowest port index wins.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module oclib_csr_space_decode
  import oclib_pkg::*;
#(
  parameter int                    Ports    = 2,
  parameter logic [Ports-1:0][3:0] SpaceMap = '0,
  localparam int                   SelWidth = (Ports > 1) ? $clog2(Ports) : 1
) (
  input  logic [3:0]          space,
  output logic [SelWidth-1:0] sel,
  output logic                hit
);

  // Scan from the top down so the lowest matching index is the last write.
  always_comb begin
    sel = '0;
    hit = 1'b0;
    for (int p = Ports - 1; p >= 0; p--) begin
      if (SpaceMap[p] == space) begin
        sel = SelWidth'(p);
        hit = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/oclib_csr_splitter.sv
// +----------------------------------------------------------------------------+
// | oclib_csr_splitter                                                         |
// | Routes one CSR request stream to N ports by space, with timeout watchdog.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module oclib_csr_splitter
  import oclib_pkg::*;
#(
  parameter int                    Ports         = 2,
  parameter type                   CsrType       = csr_32_s,
  parameter type                   CsrFbType     = csr_32_fb_s,
  parameter logic [Ports-1:0][3:0] SpaceMap      = '0,
  parameter logic [3:0]            AnswerToBlock = BcBlockIdAny,
  parameter int                    TimeoutCycles = 1024
) (
  input  logic                  clock,
  input  logic                  reset,
  input  CsrType                in,
  output CsrFbType              inFb,
  output CsrType [Ports-1:0]    out,
  input  CsrFbType [Ports-1:0]  outFb,
  output logic [15:0]           timeoutCount,
  output logic [15:0]           errorCount,
  output logic                  busy
);

  localparam int SelWidth     = (Ports > 1) ? $clog2(Ports) : 1;
  localparam int TimerWidth   = $clog2(TimeoutCycles + 2);
  localparam bit TimerEnabled = (TimeoutCycles != 0);

  csr_split_state_e      r_state;
  logic [SelWidth-1:0]   r_sel;
  logic                  r_hit;
  logic [TimerWidth-1:0] r_timer;

  logic [SelWidth-1:0]   w_sel;
  logic                  w_hit;
  logic                  w_request;
  logic                  w_accept;
  logic                  w_expired;
  logic                  w_issueWrite;
  logic                  w_issueRead;

  oclib_csr_space_decode #(
    .Ports    (Ports),
    .SpaceMap (SpaceMap)
  ) uDecode (
    .space (in.space),
    .sel   (w_sel),
    .hit   (w_hit)
  );

  assign w_request    = in.read | in.write;
  assign w_accept     = (AnswerToBlock == BcBlockIdAny) ||
                        (in.toblock == AnswerToBlock)   ||
                        (in.toblock == BcBlockIdAny);
  assign w_expired    = TimerEnabled && (r_timer == TimerWidth'(TimeoutCycles));
  // A simultaneous read and write is resolved as a write.
  assign w_issueWrite = in.write;
  assign w_issueRead  = in.read & ~in.write;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= CsrSplitStateIdle;
      r_sel        <= '0;
      r_hit        <= 1'b0;
      r_timer      <= '0;
      inFb         <= '0;
      out          <= '0;
      timeoutCount <= '0;
      errorCount   <= '0;
      busy         <= 1'b0;
    end else begin
      inFb.ready <= 1'b0;
      for (int p = 0; p < Ports; p++) begin
        out[p]       <= in;
        out[p].read  <= 1'b0;
        out[p].write <= 1'b0;
      end

      case (r_state)
        CsrSplitStateIdle: begin
          if (w_request && w_accept) begin
            r_sel   <= w_sel;
            r_hit   <= w_hit;
            busy    <= 1'b1;
            r_state <= CsrSplitStateDecode;
          end
        end

        CsrSplitStateDecode: begin
          if (r_hit) begin
            out[r_sel].write <= w_issueWrite;
            out[r_sel].read  <= w_issueRead;
            r_timer          <= TimerWidth'(1);
            r_state          <= CsrSplitStateIssue;
          end else begin
            inFb.ready <= 1'b1;
            inFb.error <= 1'b1;
            inFb.rdata <= CsrSplitErrorData;
            errorCount <= satInc16(errorCount);
            r_state    <= CsrSplitStateRespond;
          end
        end

        CsrSplitStateIssue: begin
          if (outFb[r_sel].ready) begin
            inFb.ready <= 1'b1;
            inFb.error <= outFb[r_sel].error;
            inFb.rdata <= outFb[r_sel].rdata;
            if (outFb[r_sel].error) begin
              errorCount <= satInc16(errorCount);
            end
            r_state <= CsrSplitStateRespond;
          end else if (w_expired) begin
            inFb.ready   <= 1'b1;
            inFb.error   <= 1'b1;
            inFb.rdata   <= CsrSplitErrorData;
            timeoutCount <= satInc16(timeoutCount);
            errorCount   <= satInc16(errorCount);
            r_state      <= CsrSplitStateRespond;
          end else begin
            out[r_sel].write <= w_issueWrite;
            out[r_sel].read  <= w_issueRead;
            if (TimerEnabled) begin
              r_timer <= r_timer + TimerWidth'(1);
            end
          end
        end

        CsrSplitStateRespond: begin
          r_state <= CsrSplitStateRelease;
        end

        CsrSplitStateRelease: begin
          // Hold off until the requester drops, so a held request is not re-accepted.
          if (!w_request) begin
            busy    <= 1'b0;
            r_state <= CsrSplitStateIdle;
          end
        end

        default: begin
          busy    <= 1'b0;
          r_state <= CsrSplitStateIdle;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_oclib_csr_splitter.sv
// +----------------------------------------------------------------------------+
// | tb_oclib_csr_splitter                                                      |
// | Scoreboard bench: directed CSR transactions against a 4-port splitter.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_oclib_csr_splitter;
  import oclib_pkg::*;

  logic                clock = 1'b0;
  logic                reset = 1'b0;
  csr_32_s             reqIn = '0;
  csr_32_fb_s          inFb;
  csr_32_s [3:0]       out;
  csr_32_fb_s [3:0]    outFb = '0;
  logic [15:0]         timeoutCount;
  logic [15:0]         errorCount;
  logic                busy;

  oclib_csr_splitter #(
    .Ports         (4),
    .CsrType       (csr_32_s),
    .CsrFbType     (csr_32_fb_s),
    .SpaceMap      ({4'd3, 4'd2, 4'd1, 4'd0}),
    .AnswerToBlock (4'd5),
    .TimeoutCycles (8)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .in           (reqIn),
    .inFb         (inFb),
    .out          (out),
    .outFb        (outFb),
    .timeoutCount (timeoutCount),
    .errorCount   (errorCount),
    .busy         (busy)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    errors++;
    $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          at;
  } resp_t;

  typedef struct {
    int          port;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          startAt;
    int          endAt;
  } ds_t;

  resp_t sq[$];
  ds_t   dq[$];
  int    dsCount = 0;
  int    expDs   = 0;
  int    expErr  = 0;
  int    expTo   = 0;

  // Downstream port models: ready after a programmed delay, plus scheduled stray pulses.
  int          respDelay[4] = '{-1, -1, -1, -1};
  logic [31:0] respData[4]  = '{32'h0, 32'h0, 32'h0, 32'h0};
  logic        respErr[4]   = '{1'b0, 1'b0, 1'b0, 1'b0};
  int          strayAt[4]   = '{-1, -1, -1, -1};
  int          cnt[4]       = '{0, 0, 0, 0};

  always @(negedge clock) begin
    for (int p = 0; p < 4; p++) begin
      if (out[p].read || out[p].write) begin
        cnt[p]++;
        outFb[p].ready = (respDelay[p] >= 0) && (cnt[p] == respDelay[p] + 1);
        outFb[p].rdata = respData[p];
        outFb[p].error = respErr[p];
      end else begin
        cnt[p]         = 0;
        outFb[p].ready = (cyc == strayAt[p]);
        outFb[p].rdata = 32'hDEAD_BEEF;
        outFb[p].error = 1'b0;
      end
    end
  end

  logic [3:0] prevAct   = '0;
  logic       prevReady = 1'b0;
  ds_t        cur;

  always @(negedge clock) begin : monitor
    logic [3:0] act;
    resp_t      e;
    for (int p = 0; p < 4; p++) act[p] = out[p].read | out[p].write;

    if (inFb.ready) begin
      chk("rsp_single_cycle", prevReady, 1'b0);
      if (sq.size() == 0) begin
        flag("rsp_unexpected", inFb.rdata, 0);
      end else begin
        e = sq.pop_front();
        chk("rsp_rdata", inFb.rdata, e.rdata);
        chk("rsp_error", inFb.error, e.err);
        chk("rsp_cycle", cyc, e.at);
      end
    end
    prevReady = inFb.ready;

    for (int p = 0; p < 4; p++) begin
      if (act[p] && !prevAct[p]) begin
        dsCount++;
        if (dq.size() == 0) begin
          flag("ds_unexpected", p, 0);
        end else begin
          cur = dq.pop_front();
          chk("ds_port", p, cur.port);
          chk("ds_onehot", $countones(act), 1);
          chk("ds_write", out[p].write, cur.wr);
          chk("ds_read", out[p].read, !cur.wr);
          chk("ds_addr", out[p].address, cur.addr);
          chk("ds_wdata", out[p].wdata, cur.wdata);
          chk("ds_start", cyc, cur.startAt);
        end
      end
      if (!act[p] && prevAct[p] && cur.endAt >= 0) begin
        chk("ds_end", cyc, cur.endAt);
      end
    end
    prevAct = act;
  end

  function automatic resp_t mkResp(input logic [31:0] d, input logic e, input int at);
    resp_t r;
    r.rdata = d; r.err = e; r.at = at;
    return r;
  endfunction

  function automatic ds_t mkDs(input int p, input logic wr, input logic [31:0] a,
                               input logic [31:0] wd, input int s, input int en);
    ds_t d;
    d.port = p; d.wr = wr; d.addr = a; d.wdata = wd; d.startAt = s; d.endAt = en;
    return d;
  endfunction

  // Called just after a falling edge; the request is first sampled at the next rising edge.
  task automatic issue(input logic rd, input logic wr, input logic [3:0] sp, input logic [3:0] tob,
                       input logic [31:0] addr, input logic [31:0] wd, input int holdExtra);
    bit got = 0;
    reqIn.read    = rd;
    reqIn.write   = wr;
    reqIn.space   = sp;
    reqIn.toblock = tob;
    reqIn.address = addr;
    reqIn.wdata   = wd;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clock);
      if (inFb.ready) got = 1;
    end
    if (!got) flag("rsp_wait_expired", 0, 1);
    repeat (holdExtra) @(negedge clock);
    reqIn.read  = 1'b0;
    reqIn.write = 1'b0;
    repeat (3) @(negedge clock);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clock);
    chk("rst_inFb", inFb, '0);
    chk("rst_out_zero", (out == '0), 1'b1);
    chk("rst_timeoutCount", timeoutCount, 16'h0);
    chk("rst_errorCount", errorCount, 16'h0);
    chk("rst_busy", busy, 1'b0);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    // Write to space 2, port 2 answers 3 cycles after assertion.
    respDelay[2] = 3; respData[2] = 32'h0; respErr[2] = 1'b0;
    n = cyc;
    dq.push_back(mkDs(2, 1'b1, 32'h0000_0020, 32'hA5A5_0001, n + 2, n + 6)); expDs++;
    sq.push_back(mkResp(32'h0, 1'b0, n + 6));
    issue(1'b0, 1'b1, 4'd2, 4'd5, 32'h0000_0020, 32'hA5A5_0001, 1);
    chk("busy_after_write", busy, 1'b0);

    // Read to space 1 using the broadcast block ID.
    respDelay[1] = 1; respData[1] = 32'h1234_5678; respErr[1] = 1'b0;
    n = cyc;
    dq.push_back(mkDs(1, 1'b0, 32'h0000_0014, 32'h0, n + 2, n + 4)); expDs++;
    sq.push_back(mkResp(32'h1234_5678, 1'b0, n + 4));
    issue(1'b1, 1'b0, 4'd1, BcBlockIdAny, 32'h0000_0014, 32'h0, 1);

    // Unmapped space.
    n = cyc;
    sq.push_back(mkResp(32'h0, 1'b1, n + 2)); expErr++;
    issue(1'b1, 1'b0, 4'd9, 4'd5, 32'h0000_0090, 32'h0, 1);
    chk("unmapped_errorCount", errorCount, expErr);
    chk("unmapped_timeoutCount", timeoutCount, expTo);

    // Port-reported error passes through.
    respDelay[3] = 0; respData[3] = 32'h0BAD_0003; respErr[3] = 1'b1;
    n = cyc;
    dq.push_back(mkDs(3, 1'b0, 32'h0000_0030, 32'h0, n + 2, n + 3)); expDs++;
    sq.push_back(mkResp(32'h0BAD_0003, 1'b1, n + 3)); expErr++;
    issue(1'b1, 1'b0, 4'd3, 4'd5, 32'h0000_0030, 32'h0, 1);
    chk("porterr_errorCount", errorCount, expErr);

    // Timeout: port 0 silent, stray ready on port 1 mid-ISSUE and on port 0 after.
    respDelay[0] = -1;
    n = cyc;
    strayAt[1] = n + 5;
    strayAt[0] = n + 11;
    dq.push_back(mkDs(0, 1'b0, 32'h0000_0004, 32'h0, n + 2, n + 10)); expDs++;
    sq.push_back(mkResp(32'h0, 1'b1, n + 10)); expErr++; expTo++;
    issue(1'b1, 1'b0, 4'd0, 4'd5, 32'h0000_0004, 32'h0, 1);
    chk("timeout_timeoutCount", timeoutCount, expTo);
    chk("timeout_errorCount", errorCount, expErr);
    chk("timeout_busy", busy, 1'b0);

    // Block ID mismatch is ignored entirely.
    reqIn.write = 1'b1; reqIn.read = 1'b0; reqIn.space = 4'd2; reqIn.toblock = 4'd3;
    reqIn.address = 32'h0000_0024; reqIn.wdata = 32'h5555_AAAA;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      chk("filter_busy", busy, 1'b0);
    end
    reqIn.write = 1'b0;
    repeat (2) @(negedge clock);

    // Requester holds 5 cycles past ready: still one downstream transaction.
    respDelay[1] = 2;
    n = cyc;
    dq.push_back(mkDs(1, 1'b1, 32'h0000_0018, 32'h0000_0008, n + 2, n + 5)); expDs++;
    sq.push_back(mkResp(32'h1234_5678, 1'b0, n + 5));
    issue(1'b0, 1'b1, 4'd1, 4'd5, 32'h0000_0018, 32'h0000_0008, 5);
    chk("hold_ds_count", dsCount, expDs);

    // Read and write together behave as a write.
    respDelay[3] = 0; respData[3] = 32'h0000_0033; respErr[3] = 1'b0;
    n = cyc;
    dq.push_back(mkDs(3, 1'b1, 32'h0000_0034, 32'hCAFE_0003, n + 2, n + 3)); expDs++;
    sq.push_back(mkResp(32'h0000_0033, 1'b0, n + 3));
    issue(1'b1, 1'b1, 4'd3, 4'd5, 32'h0000_0034, 32'hCAFE_0003, 1);

    // Asynchronous reset during ISSUE aborts without a response.
    respDelay[2] = -1;
    n = cyc;
    dq.push_back(mkDs(2, 1'b1, 32'h0000_0028, 32'h7777_0002, n + 2, -1)); expDs++;
    reqIn.write = 1'b1; reqIn.read = 1'b0; reqIn.space = 4'd2; reqIn.toblock = 4'd5;
    reqIn.address = 32'h0000_0028; reqIn.wdata = 32'h7777_0002;
    repeat (4) @(negedge clock);
    chk("pre_reset_issue", out[2].write, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk("areset_inFb", inFb, '0);
    chk("areset_out_zero", (out == '0), 1'b1);
    chk("areset_busy", busy, 1'b0);
    chk("areset_timeoutCount", timeoutCount, 16'h0);
    chk("areset_errorCount", errorCount, 16'h0);
    expErr = 0; expTo = 0;
    reqIn.write = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    // Recovery after reset.
    respDelay[0] = 0; respData[0] = 32'hC0FF_EE00; respErr[0] = 1'b0;
    n = cyc;
    dq.push_back(mkDs(0, 1'b0, 32'h0000_0008, 32'h0, n + 2, n + 3)); expDs++;
    sq.push_back(mkResp(32'hC0FF_EE00, 1'b0, n + 3));
    issue(1'b1, 1'b0, 4'd0, 4'd5, 32'h0000_0008, 32'h0, 1);
    chk("recover_errorCount", errorCount, expErr);
    chk("recover_timeoutCount", timeoutCount, expTo);

    repeat (4) @(negedge clock);
    chk("end_resp_queue_empty", sq.size(), 0);
    chk("end_ds_queue_empty", dq.size(), 0);
    chk("end_ds_count", dsCount, expDs);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit: got %0d expected 0 (cycle %0d)", 1, cyc);
    $fatal(1, "time limit");
  end

endmodule

`default_nettype wire

// File: doc/oclib_csr_splitter.md
# oclib_csr_splitter

Single-clock CSR fan-out that accepts one normalized csr_32 request stream and routes each transaction to one of `Ports` downstream CSR ports, selected by the request's space field through a per-port space map. It adds a per-transaction timeout watchdog, error responses for unmapped spaces and timed-out ports, and status counters. It sits after the CSR adapter or bus bridge and in front of multiple register blocks, replacing ad-hoc space muxing in top-level glue.

## Interface
- `Ports`, 2: number of downstream ports, 1..16.
- `CsrType`, `oclib_pkg::csr_32_s`: request type for `in` and `out`.
- `CsrFbType`, `oclib_pkg::csr_32_fb_s`: feedback type.
- `SpaceMap`, `{16{4'h0}}`: packed `[Ports-1:0][3:0]` list; port p answers space `SpaceMap[p]`. The lowest index wins on duplicates.
- `AnswerToBlock`, `oclib_pkg::BcBlockIdAny`: block ID accepted; `BcBlockIdAny` accepts all.
- `TimeoutCycles`, 1024: cycles in ISSUE before forced error; 0 disables the watchdog.
- `clock` (in, 1): sole clock.
- `reset` (in, 1): asynchronous, active-low.
- `in` (in, CsrType): upstream request.
- `inFb` (out, CsrFbType): upstream response.
- `out` (out, `CsrType [Ports-1:0]`): downstream requests.
- `outFb` (in, `CsrFbType [Ports-1:0]`): downstream responses.
- `timeoutCount` (out, 16): saturating count of timeouts.
- `errorCount` (out, 16): saturating count of all error responses, including timeouts.
- `busy` (out, 1): high when the FSM is not in IDLE.

## Operation
- Protocol on both sides: the requester holds `read` or `write` and all fields stable until `ready` pulses for one cycle, then drops the request for at least one cycle. `read` and `write` are never high together; if both are high, the request is treated as a write.
- Block filter: a request whose `toblock` is not `AnswerToBlock`, and is not `BcBlockIdAny` when `AnswerToBlock` is not Any, is ignored. No response is driven and the FSM stays in IDLE.
- FSM states and transitions:
  - IDLE: on an accepted request, register the decode (port index, `hit`) and go to DECODE.
  - DECODE: if `hit`, go to ISSUE. If not `hit`, go to RESPOND with `error=1`, `rdata=0`.
  - ISSUE: `out[sel]` carries the held request with `read`/`write` gated on. All other ports have `read=write=0`; their address and data fields mirror `in`.
    - On `outFb[sel].ready`: capture `rdata` and `error`, then go to RESPOND.
    - On timer expiry: go to RESPOND with `error=1`, `rdata=32'h0`, and increment `timeoutCount`.
  - RESPOND: drive `inFb.ready=1` for exactly one cycle with the captured data and error, then go to RELEASE.
  - RELEASE: wait until `in.read==0 && in.write==0`, then go to IDLE. This prevents a held request from being accepted twice.
- A `ready` from a non-selected port, or a late `ready` after a timeout, is ignored.
- `errorCount` increments once per RESPOND cycle that has `error=1`. Both counters saturate at 16'hFFFF.

## Timing
- Cycle 0: request seen in IDLE. Cycle 1: DECODE. Cycle 2: `out[sel]` request asserted.
- Downstream `ready` at cycle k gives `inFb.ready` at k+1, and `out[sel]` request deasserted at k+1 (registered).
- Unmapped space: `inFb.ready` with `error=1` at cycle 2.
- Timeout: the timer counts ISSUE cycles starting at 1. When it reaches `TimeoutCycles`, `out` is deasserted the next cycle and the response follows in that same next cycle.
- All outputs are registered, including all `out`/`inFb` fields.
- Reset values: all `out` fields 0, all `inFb` fields 0, counters 0, `busy=0`, FSM in IDLE.
- Reset asserted mid-transaction aborts it immediately with no response. The upstream requester is expected to retry after reset.

## Structure
- Add `oclib_pkg::CsrSplitStateIdle..Release` as the FSM state enum.
- Add `oclib_pkg::CsrSplitErrorData = 32'h0`.
- Make the space decode a sub-module, `oclib_csr_space_decode`: combinational, with a `Ports`/`SpaceMap` priority match that outputs an index and `hit`.
- FSM, timer and counters live in the top module.

## Test plan
- `Ports=4`, `SpaceMap={3,2,1,0}`; write to space 2 with `wdata=32'hA5A5_0001`, and port 2 `ready` 3 cycles after assertion. Required: only `out[2].write` goes high, at cycle 2, and `inFb.ready` arrives 1 cycle after port `ready` with `error=0`.
- Read to space 1, port returns `rdata=32'h1234_5678`. Required: `inFb.rdata=32'h1234_5678` and `ready` high for exactly one cycle.
- Request to space 9, which is unmapped. Required: no `out` activity; `inFb.ready` with `error=1` and `rdata=0` at cycle 2; `errorCount=1`.
- `TimeoutCycles=8` and the port never responds. Required: response with `error=1` after 8 ISSUE cycles; `timeoutCount=1`; a later stray port `ready` is ignored.
- `toblock` mismatching `AnswerToBlock=5`. Required: no response and `busy` stays 0.
- Upstream holds the request for 5 cycles past `ready`. Required: exactly one downstream transaction. Separately, `reset` pulsed low during ISSUE: all outputs return to 0 asynchronously.
